// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch-control bus: pcGen fetch PC/stall/redirect, I-cache req/rsp, decode handoff.
// slave = fetch controller side, master = surrounding pipeline/environment side.
interface ifu_fetch_ctrl_if #(
    parameter int MXLEN = 32
);
    logic [MXLEN-1:0] i_pcGen_fetch_pc;
    logic             i_pcGen_fetch_valid;
    logic             o_fetch_pcGen_stall;
    logic             i_pcRedirect_fetch_flush;
    logic             o_fetch_icache_req_valid;
    logic [MXLEN-1:0] o_fetch_icache_req_pc;
    logic             i_icache_fetch_req_ready;
    logic             i_icache_fetch_rsp_valid;
    logic [127:0]     i_icache_fetch_rsp_data;
    logic             i_icache_fetch_rsp_err;
    logic             o_fetch_dec_valid;
    logic [MXLEN-1:0] o_fetch_dec_pc;
    logic [127:0]     o_fetch_dec_instr;
    logic [3:0]       o_fetch_dec_mask;
    logic             o_fetch_dec_err;
    logic             i_dec_fetch_ready;

    modport slave (
        input  i_pcGen_fetch_pc, i_pcGen_fetch_valid, i_pcRedirect_fetch_flush,
        input  i_icache_fetch_req_ready, i_icache_fetch_rsp_valid,
        input  i_icache_fetch_rsp_data, i_icache_fetch_rsp_err, i_dec_fetch_ready,
        output o_fetch_pcGen_stall, o_fetch_icache_req_valid, o_fetch_icache_req_pc,
        output o_fetch_dec_valid, o_fetch_dec_pc, o_fetch_dec_instr,
        output o_fetch_dec_mask, o_fetch_dec_err
    );

    modport master (
        output i_pcGen_fetch_pc, i_pcGen_fetch_valid, i_pcRedirect_fetch_flush,
        output i_icache_fetch_req_ready, i_icache_fetch_rsp_valid,
        output i_icache_fetch_rsp_data, i_icache_fetch_rsp_err, i_dec_fetch_ready,
        input  o_fetch_pcGen_stall, o_fetch_icache_req_valid, o_fetch_icache_req_pc,
        input  o_fetch_dec_valid, o_fetch_dec_pc, o_fetch_dec_instr,
        input  o_fetch_dec_mask, o_fetch_dec_err
    );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Fetch controller: issues I-cache block requests from the fetch PC, tracks
// in-flight requests, buffers returned blocks for decode, drops stale data after flush.
// Ports: i_clk, i_rst_n (async active-low), bus (ifu_fetch_ctrl_if.slave).
module ifu_fetch_ctrl #(
    parameter int MXLEN      = 32,
    parameter int MAX_OUTST  = 2,
    parameter int FBUF_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    ifu_fetch_ctrl_if.slave  bus
);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int BW = (FBUF_DEPTH > 1) ? $clog2(FBUF_DEPTH) : 1;
    localparam int CW = $clog2(FBUF_DEPTH + 1);
    localparam logic [7:0]    FB_LIM  = 8'(FBUF_DEPTH);
    localparam logic [OW-1:0] OUT_LIM = OW'(MAX_OUTST);
    localparam logic [PW-1:0] PC_LAST = PW'(MAX_OUTST - 1);

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_e;

    state_e           state_q, state_d;
    logic [OW-1:0]    outst_q, outst_d;
    logic [OW-1:0]    drop_q, drop_d;
    logic [MXLEN-1:0] pcf_q [MAX_OUTST];
    logic [PW-1:0]    pcf_wp_q, pcf_wp_d;
    logic [PW-1:0]    pcf_rp_q, pcf_rp_d;
    logic [MXLEN-1:0] fb_pc_q [FBUF_DEPTH];
    logic [127:0]     fb_data_q [FBUF_DEPTH];
    logic             fb_err_q [FBUF_DEPTH];
    logic [BW-1:0]    fb_wp_q, fb_wp_d;
    logic [BW-1:0]    fb_rp_q, fb_rp_d;
    logic [CW-1:0]    fb_cnt_q, fb_cnt_d;

    logic       flush, rsp, acc, enq, deq, dropping, can_issue, req_valid, dec_valid;
    logic [7:0] used;
    logic [MXLEN-1:0] pc_head, head_pc;

    assign flush    = bus.i_pcRedirect_fetch_flush;
    assign rsp      = bus.i_icache_fetch_rsp_valid;
    assign dropping = (drop_q != '0);
    // In-flight requests reserve buffer slots so a response never overflows.
    assign used      = 8'(outst_q) + 8'(fb_cnt_q);
    assign can_issue = (state_q == RUN) && (used < FB_LIM) && (outst_q < OUT_LIM);
    // Reset gating keeps req_valid low while rst_n is held, independent of inputs.
    assign req_valid = bus.i_pcGen_fetch_valid & can_issue & ~flush & i_rst_n;
    assign acc       = req_valid & bus.i_icache_fetch_req_ready;
    assign dec_valid = (fb_cnt_q != '0);
    assign enq       = rsp & ~flush & ~dropping;
    assign deq       = dec_valid & bus.i_dec_fetch_ready & ~flush;
    assign pc_head   = pcf_q[pcf_rp_q];
    assign head_pc   = fb_pc_q[fb_rp_q];

    assign bus.o_fetch_icache_req_valid = req_valid;
    assign bus.o_fetch_icache_req_pc    = {bus.i_pcGen_fetch_pc[MXLEN-1:4], 4'b0};
    assign bus.o_fetch_pcGen_stall      = ~acc;
    assign bus.o_fetch_dec_valid        = dec_valid;
    assign bus.o_fetch_dec_pc           = head_pc;
    assign bus.o_fetch_dec_instr        = fb_data_q[fb_rp_q];
    assign bus.o_fetch_dec_mask         = 4'b1111 << head_pc[3:2];
    assign bus.o_fetch_dec_err          = dec_valid & fb_err_q[fb_rp_q];

    function automatic logic [PW-1:0] pcf_nxt(input logic [PW-1:0] p);
        return (p == PC_LAST) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        state_d  = state_q;
        outst_d  = outst_q;
        drop_d   = drop_q;
        pcf_wp_d = pcf_wp_q;
        pcf_rp_d = pcf_rp_q;
        fb_wp_d  = fb_wp_q;
        fb_rp_d  = fb_rp_q;
        fb_cnt_d = fb_cnt_q;
        if (flush) begin
            // Everything still in flight after this cycle is stale.
            outst_d  = outst_q - OW'(rsp);
            drop_d   = outst_d;
            state_d  = (outst_d != '0) ? DRAIN : RUN;
            pcf_wp_d = '0;
            pcf_rp_d = '0;
            fb_wp_d  = '0;
            fb_rp_d  = '0;
            fb_cnt_d = '0;
        end else begin
            outst_d = outst_q + OW'(acc) - OW'(rsp);
            if (acc)             pcf_wp_d = pcf_nxt(pcf_wp_q);
            if (rsp && !dropping) pcf_rp_d = pcf_nxt(pcf_rp_q);
            if (enq)             fb_wp_d  = fb_wp_q + BW'(1);
            if (deq)             fb_rp_d  = fb_rp_q + BW'(1);
            fb_cnt_d = fb_cnt_q + CW'(enq) - CW'(deq);
            unique case (state_q)
                RUN: begin
                    if (enq && bus.i_icache_fetch_rsp_err) state_d = HALT;
                end
                DRAIN: begin
                    if (rsp) begin
                        drop_d = drop_q - OW'(1);
                        if (drop_q == OW'(1)) state_d = RUN;
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= RUN;
            outst_q  <= '0;
            drop_q   <= '0;
            pcf_wp_q <= '0;
            pcf_rp_q <= '0;
            fb_wp_q  <= '0;
            fb_rp_q  <= '0;
            fb_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            pcf_wp_q <= pcf_wp_d;
            pcf_rp_q <= pcf_rp_d;
            fb_wp_q  <= fb_wp_d;
            fb_rp_q  <= fb_rp_d;
            fb_cnt_q <= fb_cnt_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < MAX_OUTST; i++) pcf_q[i] <= '0;
        end else if (acc) begin
            pcf_q[pcf_wp_q] <= bus.i_pcGen_fetch_pc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FBUF_DEPTH; i++) begin
                fb_pc_q[i]   <= '0;
                fb_data_q[i] <= '0;
                fb_err_q[i]  <= 1'b0;
            end
        end else if (enq) begin
            fb_pc_q[fb_wp_q]   <= pc_head;
            fb_data_q[fb_wp_q] <= bus.i_icache_fetch_rsp_data;
            fb_err_q[fb_wp_q]  <= bus.i_icache_fetch_rsp_err;
        end
    end

    a_rsp_has_req: assert property (
        @(posedge i_clk) disable iff (!i_rst_n) rsp |-> (outst_q != '0));
endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Self-checking bench for ifu_fetch_ctrl: directed vector table, corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_ifu_fetch_ctrl;
    localparam int MO = 2;
    localparam int FD = 4;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifu_fetch_ctrl_if #(.MXLEN(32)) bus ();

    ifu_fetch_ctrl #(.MXLEN(32), .MAX_OUTST(MO), .FBUF_DEPTH(FD)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus.slave)
    );

    int n_chk = 0;
    int n_pass = 0;
    logic last_acc;

    typedef struct {
        logic [31:0] pc;
        bit          stale;
    } inf_t;
    typedef struct {
        logic [31:0]  pc;
        logic [127:0] data;
        logic         err;
    } fb_t;
    inf_t infl[$];
    fb_t  fbuf[$];
    bit   halted;

    typedef struct {
        logic pv; logic [31:0] pc; logic rdy, rv, fl, dr;
        logic rq; logic [31:0] rqpc; logic st, dv;
        logic [31:0] dpc; logic [3:0] dm; logic de;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic bit m_stale();
        foreach (infl[i]) if (infl[i].stale) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_rq();
        return bus.i_pcGen_fetch_valid && !bus.i_pcRedirect_fetch_flush && !halted
            && !m_stale() && infl.size() < MO && (infl.size() + fbuf.size()) < FD;
    endfunction

    function automatic logic [3:0] m_mask(input logic [31:0] pc);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = (i >= int'(pc[3:2]));
        return m;
    endfunction

    task automatic drive(input logic pv, input logic [31:0] pc, input logic rdy,
                         input logic rv, input logic [127:0] d, input logic err,
                         input logic fl, input logic dr);
        bus.i_pcGen_fetch_valid      = pv;
        bus.i_pcGen_fetch_pc         = pc;
        bus.i_icache_fetch_req_ready = rdy;
        bus.i_icache_fetch_rsp_valid = rv;
        bus.i_icache_fetch_rsp_data  = d;
        bus.i_icache_fetch_rsp_err   = err;
        bus.i_pcRedirect_fetch_flush = fl;
        bus.i_dec_fetch_ready        = dr;
        #3;
    endtask

    task automatic mcheck();
        logic rq;
        rq = m_rq();
        chk("req_valid", bus.o_fetch_icache_req_valid, rq);
        if (rq) chk("req_pc", bus.o_fetch_icache_req_pc, {bus.i_pcGen_fetch_pc[31:4], 4'b0});
        chk("stall", bus.o_fetch_pcGen_stall, !(rq && bus.i_icache_fetch_req_ready));
        chk("dec_valid", bus.o_fetch_dec_valid, fbuf.size() > 0);
        if (fbuf.size() > 0) begin
            chk("dec_pc", bus.o_fetch_dec_pc, fbuf[0].pc);
            chk("dec_instr", bus.o_fetch_dec_instr, fbuf[0].data);
            chk("dec_mask", bus.o_fetch_dec_mask, m_mask(fbuf[0].pc));
            chk("dec_err", bus.o_fetch_dec_err, fbuf[0].err);
        end else begin
            chk("dec_err_idle", bus.o_fetch_dec_err, 1'b0);
        end
        last_acc = bus.o_fetch_icache_req_valid & bus.i_icache_fetch_req_ready;
    endtask

    task automatic step();
        bit   acc, deq;
        inf_t e;
        acc = m_rq() && bus.i_icache_fetch_req_ready;
        deq = fbuf.size() > 0 && bus.i_dec_fetch_ready;
        @(posedge clk);
        #1;
        if (bus.i_pcRedirect_fetch_flush) begin
            if (bus.i_icache_fetch_rsp_valid) void'(infl.pop_front());
            foreach (infl[i]) infl[i].stale = 1'b1;
            fbuf.delete();
            halted = 1'b0;
        end else begin
            if (deq) void'(fbuf.pop_front());
            if (bus.i_icache_fetch_rsp_valid) begin
                e = infl.pop_front();
                if (!e.stale) begin
                    fbuf.push_back('{e.pc, bus.i_icache_fetch_rsp_data,
                                     bus.i_icache_fetch_rsp_err});
                    if (bus.i_icache_fetch_rsp_err) halted = 1'b1;
                end
            end
            if (acc) infl.push_back('{bus.i_pcGen_fetch_pc, 1'b0});
        end
    endtask

    task automatic cyc(input logic pv, input logic [31:0] pc, input logic rdy,
                       input logic rv, input logic [127:0] d, input logic err,
                       input logic fl, input logic dr);
        drive(pv, pc, rdy, rv, d, err, fl, dr);
        mcheck();
        step();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req_valid"}, bus.o_fetch_icache_req_valid, 1'b0);
        chk({tag, "_stall"}, bus.o_fetch_pcGen_stall, 1'b1);
        chk({tag, "_dec_valid"}, bus.o_fetch_dec_valid, 1'b0);
        chk({tag, "_dec_err"}, bus.o_fetch_dec_err, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.i_pcGen_fetch_valid      = 1'b1;
        bus.i_pcGen_fetch_pc         = 32'h8000_0000;
        bus.i_icache_fetch_req_ready = 1'b1;
        bus.i_icache_fetch_rsp_valid = 1'b0;
        bus.i_icache_fetch_rsp_data  = '0;
        bus.i_icache_fetch_rsp_err   = 1'b0;
        bus.i_pcRedirect_fetch_flush = 1'b0;
        bus.i_dec_fetch_ready        = 1'b0;
        infl.delete();
        fbuf.delete();
        halted = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("rst");
        bus.i_pcGen_fetch_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0]  rpc;
        logic         rpv, hold;
        int           nacc;

        tbl[0]  = '{T, 32'h8000_0000, T, F, F, T, T, 32'h8000_0000, F, F, 32'h0, 4'h0, F};
        tbl[1]  = '{T, 32'h8000_0008, T, T, F, T, T, 32'h8000_0000, F, F, 32'h0, 4'h0, F};
        tbl[2]  = '{F, 32'h0,         T, T, F, T, F, 32'h0, T, T, 32'h8000_0000, 4'hF, F};
        tbl[3]  = '{F, 32'h0,         T, F, F, T, F, 32'h0, T, T, 32'h8000_0008, 4'hC, F};
        tbl[4]  = '{T, 32'h8000_0010, T, F, F, T, T, 32'h8000_0010, F, F, 32'h0, 4'h0, F};
        tbl[5]  = '{T, 32'h8000_0014, T, F, F, T, T, 32'h8000_0010, F, F, 32'h0, 4'h0, F};
        tbl[6]  = '{T, 32'h8000_0020, T, F, T, T, F, 32'h0, T, F, 32'h0, 4'h0, F};
        tbl[7]  = '{T, 32'h8000_0020, T, T, F, T, F, 32'h0, T, F, 32'h0, 4'h0, F};
        tbl[8]  = '{T, 32'h8000_0020, T, T, F, T, F, 32'h0, T, F, 32'h0, 4'h0, F};
        tbl[9]  = '{T, 32'h8000_0024, T, F, F, T, T, 32'h8000_0020, F, F, 32'h0, 4'h0, F};
        tbl[10] = '{F, 32'h0,         T, T, F, F, F, 32'h0, T, F, 32'h0, 4'h0, F};
        tbl[11] = '{F, 32'h0,         T, F, F, T, F, 32'h0, T, T, 32'h8000_0024, 4'hE, F};

        @(posedge clk);
        #1;
        do_reset();

        // directed vector table: basic fetch, unaligned mask, flush with drain
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].pv, tbl[i].pc, tbl[i].rdy, tbl[i].rv,
                  {4{32'h1000 + 32'(i)}}, 1'b0, tbl[i].fl, tbl[i].dr);
            mcheck();
            chk($sformatf("tbl%0d_req_valid", i), bus.o_fetch_icache_req_valid, tbl[i].rq);
            if (tbl[i].rq) chk($sformatf("tbl%0d_req_pc", i), bus.o_fetch_icache_req_pc, tbl[i].rqpc);
            chk($sformatf("tbl%0d_stall", i), bus.o_fetch_pcGen_stall, tbl[i].st);
            chk($sformatf("tbl%0d_dec_valid", i), bus.o_fetch_dec_valid, tbl[i].dv);
            if (tbl[i].dv) begin
                chk($sformatf("tbl%0d_dec_pc", i), bus.o_fetch_dec_pc, tbl[i].dpc);
                chk($sformatf("tbl%0d_dec_mask", i), bus.o_fetch_dec_mask, tbl[i].dm);
            end
            chk($sformatf("tbl%0d_dec_err", i), bus.o_fetch_dec_err, tbl[i].de);
            step();
        end

        // buffer fills to 4 blocks under decode back-pressure
        nacc = 0;
        rpc = 32'h8000_0100;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, rpc, 1'b1, infl.size() > 0, {4{rpc}}, 1'b0, 1'b0, 1'b0);
            if (last_acc) begin
                nacc++;
                rpc = rpc + 32'h10;
            end
        end
        chk("full_accepts", 32'(nacc), 32'd4);
        drive(1'b1, rpc, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        mcheck();
        chk("full_req_valid", bus.o_fetch_icache_req_valid, 1'b0);
        chk("full_stall", bus.o_fetch_pcGen_stall, 1'b1);
        chk("full_dec_valid", bus.o_fetch_dec_valid, 1'b1);
        step();
        drive(1'b1, rpc, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        mcheck();
        chk("credit_back_req_valid", bus.o_fetch_icache_req_valid, 1'b1);
        step();
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 32'h0, 1'b1, infl.size() > 0, {4{32'hBEEF_0000 + 32'(i)}}, 1'b0, 1'b0, 1'b1);

        // flush coincident with the first of two responses
        cyc(1'b1, 32'h8000_0200, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h8000_0210, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h8000_0300, 1'b1, 1'b1, {4{32'hDEAD_0001}}, 1'b0, 1'b1, 1'b1);
        mcheck();
        chk("fl_rsp_req_valid", bus.o_fetch_icache_req_valid, 1'b0);
        step();
        drive(1'b1, 32'h8000_0300, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        mcheck();
        chk("drain_req_valid", bus.o_fetch_icache_req_valid, 1'b0);
        step();
        drive(1'b1, 32'h8000_0300, 1'b1, 1'b1, {4{32'hDEAD_0002}}, 1'b0, 1'b0, 1'b1);
        mcheck();
        chk("drain_last_req_valid", bus.o_fetch_icache_req_valid, 1'b0);
        step();
        drive(1'b1, 32'h8000_0300, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        mcheck();
        chk("resume_req_valid", bus.o_fetch_icache_req_valid, 1'b1);
        chk("resume_dec_valid", bus.o_fetch_dec_valid, 1'b0);
        step();
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 32'h0, 1'b1, infl.size() > 0, {4{32'h0300_0000 + 32'(i)}}, 1'b0, 1'b0, 1'b1);

        // access fault halts fetch until a redirect
        cyc(1'b1, 32'h8000_0404, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, {4{32'hE000_0000}}, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'h8000_0500, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        mcheck();
        chk("err_dec_err", bus.o_fetch_dec_err, 1'b1);
        chk("err_dec_mask", bus.o_fetch_dec_mask, 4'b1110);
        chk("halt_req_valid", bus.o_fetch_icache_req_valid, 1'b0);
        step();
        drive(1'b1, 32'h8000_0500, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        mcheck();
        chk("halt_empty_req_valid", bus.o_fetch_icache_req_valid, 1'b0);
        step();
        cyc(1'b1, 32'h8000_0600, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 32'h8000_0600, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        mcheck();
        chk("unhalt_req_valid", bus.o_fetch_icache_req_valid, 1'b1);
        step();
        cyc(1'b1, 32'h8000_0610, 1'b1, infl.size() > 0, {4{32'h0600_0000}}, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h8000_0620, 1'b1, infl.size() > 0, {4{32'h0600_0001}}, 1'b0, 1'b0, 1'b0);
        // asynchronous reset mid-burst
        bus.i_pcGen_fetch_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("async");
        do_reset();

        // randomized traffic against the reference model
        hold = 1'b0;
        rpv  = 1'b0;
        rpc  = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            if (!hold) begin
                rpv = ($urandom_range(0, 3) != 0);
                rpc = $urandom;
            end
            cyc(rpv, rpc, $urandom_range(0, 9) < 7,
                (infl.size() > 0) && ($urandom_range(0, 1) == 1),
                {$urandom, $urandom, $urandom, $urandom},
                $urandom_range(0, 39) == 0, $urandom_range(0, 24) == 0,
                $urandom_range(0, 9) < 6);
            hold = rpv && !last_acc;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
